imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The datapath fetches from this memory and the control unit decodes what it fetches.
- Accepts a framed byte stream from a host link (e.g. UART RX) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the processor in reset until a complete, checked image has been loaded.

Parameters:
- ADDR_WIDTH, 8, width of the word address into instruction memory (capacity 2**ADDR_WIDTH words).
- BASE_ADDR, 0, word address of the first loaded instruction.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  ADDR_WIDTH  word address for write
- mem_wdata  output  32  instruction word
- cpu_reset  output  1  active-high reset to processor core
- done  output  1  image loaded and verified
- error  output  1  frame error, sticky

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state is cleared asynchronously on reset_n low.
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, state=IDLE. rx_ready rises the first cycle after reset_n deasserts.
- rx_ready is 1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM and DONE; it is 0 in ERR. The loader never back-pressures mid-frame.
- Frame format: MAGIC, LEN_LO, LEN_HI, then 4*N data bytes, then CSUM. N = {LEN_HI, LEN_LO} words. CSUM = XOR of all data bytes only (header excluded).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: a byte equal to MAGIC moves to LEN_LO; any other byte is discarded.
- LEN_LO -> LEN_HI on the next accepted byte.
- LEN_HI, on the next accepted byte:
  - N > 2**ADDR_WIDTH - BASE_ADDR -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA, with byte counter and word index cleared and running XOR cleared.
- DATA: bytes are packed little-endian; the first byte of a word goes to [7:0] and the fourth to [31:24].
- Word write timing: when the 4th byte of word k is accepted at edge t, then in the cycle after t:
  - mem_we=1
  - mem_addr=BASE_ADDR+k (ADDR_WIDTH bits)
  - mem_wdata=assembled word
- Outside write cycles mem_we=0; mem_addr and mem_wdata hold their last values.
- After the 4th byte of word N-1: -> CSUM.
- CSUM: accepted byte == running XOR -> DONE; mismatch -> ERR. Words already written stay in memory.
- DONE: done=1 and cpu_reset=0, both registered, starting the cycle after the CSUM byte is accepted.
- Reload from DONE: a MAGIC byte received in DONE sets cpu_reset=1 and done=0 on the next cycle and goes to LEN_LO. Non-MAGIC bytes in DONE are ignored.
- ERR: error=1, cpu_reset=1, done=0. Sticky until reset_n.
- Reset mid-frame: all progress is discarded, outputs return to reset values, and a partial image remains in memory.
- Counters: byte-in-word counter is 2 bits and wraps 3->0. The word index is 16 bits and is compared against N, so no address wrap is possible after the LEN_HI range check.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: CSUM state present and checksum verified as above.
- Undefined:
  - No CSUM byte in the frame.
  - The last word's write cycle is followed next cycle by DONE.
  - N == 0 goes LEN_HI -> DONE directly.
  - The mismatch path to ERR does not exist.

Test Plan:
- Basic load: after reset, send A5 02 00 | 01 00 A0 E3 | 02 10 A0 E3 | csum. Required response:
  - mem_we pulses twice: addr 0 data E3A00001, then addr 1 data E3A01002.
  - done=1 and cpu_reset=0 one cycle after the checksum byte.
- Bad checksum: same frame with a wrong last byte -> error=1, rx_ready=0, cpu_reset stays 1, both words still written.
- Oversize: ADDR_WIDTH=4, send A5 11 00 -> ERR after the LEN_HI byte, no mem_we.
- Noise and gapped valid: bytes 00 FF 5A before A5, then a 1-word frame with rx_valid toggling every other cycle. Required response:
  - The noise bytes are ignored.
  - Exactly one write, of the correctly assembled word.
- Reload and async reset: load 1 word, then from DONE send a new 1-word frame and check cpu_reset reasserts during the reload. Then, midway through a 2-word frame, pulse reset_n low for 1 cycle -> all outputs at reset values immediately, next A5 restarts cleanly.
- Zero length: A5 00 00 csum=00 -> DONE with no mem_we. Without the macro, A5 00 00 -> DONE.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a framed byte stream (MAGIC, LEN_LO, LEN_HI, 4*N data bytes[, CSUM])
// over valid/ready, packs little-endian 32-bit words, writes them sequentially
// starting at BASE_ADDR and keeps the core in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   - a trailing XOR checksum byte is expected and verified.
//   undefined - no checksum byte; DONE follows the last word's write cycle.
module imem_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loaderStateT;

    // Number of words that fit between BASE_ADDR and the top of memory.
    localparam logic [16:0]           CAPACITY = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    loaderStateT stateReg, stateNext;

    logic [7:0]            lenLoReg;
    logic [15:0]           lenReg;
    logic [1:0]            byteCntReg;
    logic [15:0]           wordIdxReg;
    logic [23:0]           wordBuf;
    logic                  memWeReg;
    logic [ADDR_WIDTH-1:0] memAddrReg;
    logic [31:0]           memWdataReg;
    logic                  readyReg;
    logic                  doneReg;
    logic                  errorReg;
    logic                  cpuResetReg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xorReg;
`endif

    logic        accept;
    logic [15:0] lenFull;
    logic        lastByte;
    logic        lastWord;
    logic        draining;
    logic        dataByte;

    assign accept   = rx_valid && readyReg;
    assign lenFull  = {rx_data, lenLoReg};
    assign lastByte = (byteCntReg == 2'd3);
    assign lastWord = ((wordIdxReg + 16'd1) == lenReg);
    // All N words have been written; only reachable without the checksum
    // byte, where DATA spends one extra cycle before DONE. A byte accepted
    // in that cycle lies outside the frame and is dropped.
    assign draining = (wordIdxReg == lenReg);
    assign dataByte = (stateReg == DATA) && accept && !draining;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic for the frame parser.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept && rx_data == MAGIC) stateNext = LEN_LO;
            end
            LEN_LO: begin
                if (accept) stateNext = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if ({1'b0, lenFull} > CAPACITY) begin
                        stateNext = ERR;
                    end else if (lenFull == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        stateNext = CSUM;
`else
                        stateNext = DONE;
`endif
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept && lastByte && lastWord) stateNext = CSUM;
`else
                if (draining) stateNext = DONE;
`endif
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) stateNext = (rx_data == xorReg) ? DONE : ERR;
`else
                stateNext = DONE;
`endif
            end
            DONE: begin
                if (accept && rx_data == MAGIC) stateNext = LEN_LO;
            end
            ERR: begin
                stateNext = ERR;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readyReg    <= 1'b0;
            doneReg     <= 1'b0;
            errorReg    <= 1'b0;
            cpuResetReg <= 1'b1;
        end else begin
            readyReg    <= (stateNext != ERR);
            doneReg     <= (stateNext == DONE);
            errorReg    <= (stateNext == ERR);
            cpuResetReg <= (stateNext != DONE);
        end
    end

    // Header capture and word counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lenLoReg   <= '0;
            lenReg     <= '0;
            byteCntReg <= '0;
            wordIdxReg <= '0;
        end else begin
            if (stateReg == LEN_LO && accept) begin
                lenLoReg <= rx_data;
            end
            if (stateReg == LEN_HI && accept) begin
                lenReg     <= lenFull;
                byteCntReg <= '0;
                wordIdxReg <= '0;
            end else if (dataByte) begin
                byteCntReg <= byteCntReg + 2'd1;
                if (lastByte) wordIdxReg <= wordIdxReg + 16'd1;
            end
        end
    end

    // Byte lanes 0..2 of the word being assembled; lane 3 goes straight to memory.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] laneReg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    laneReg <= '0;
                end else if (dataByte && byteCntReg == 2'(gi)) begin
                    laneReg <= rx_data;
                end
            end
            assign wordBuf[gi*8 +: 8] = laneReg;
        end
    endgenerate

    // Memory write port: one-cycle pulse after the fourth byte of each word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
        end else begin
            memWeReg <= 1'b0;
            if (dataByte && lastByte) begin
                memWeReg    <= 1'b1;
                memAddrReg  <= BASE + wordIdxReg[ADDR_WIDTH-1:0];
                memWdataReg <= {rx_data, wordBuf};
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xorReg <= '0;
        end else if (stateReg == LEN_HI && accept) begin
            xorReg <= '0;
        end else if (dataByte) begin
            xorReg <= xorReg ^ rx_data;
        end
    end
`endif

    assign rx_ready  = readyReg;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign cpu_reset = cpuResetReg;
    assign done      = doneReg;
    assign error     = errorReg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven basic load plus
// hand-written sequences for checksum error, oversize, noise/gapped valid,
// reload, asynchronous reset and zero-length frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    // Second instance with a 16-word memory for the oversize check.
    logic [7:0]  rx_data4;
    logic        rx_valid4;
    logic        rx_ready4;
    logic        mem_we4;
    logic [3:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic        cpu_reset4;
    logic        done4;
    logic        error4;

    int nChecks = 0;
    int nFail   = 0;
    int weCount = 0;
    int weCount4 = 0;
    int weBase;

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(0), .MAGIC(8'hA5)) dut4 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data4), .rx_valid(rx_valid4),
        .rx_ready(rx_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .cpu_reset(cpu_reset4), .done(done4), .error(error4)
    );

    always #5 clk = ~clk;

    // Count write pulses mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) weCount++;
        if (mem_we4 === 1'b1) weCount4++;
    end

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        dn;
        logic        err;
    } vecT;

    vecT vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendByte4(input logic [7:0] b);
        rx_data4  = b;
        rx_valid4 = 1'b1;
        @(posedge clk);
        #1;
        rx_valid4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chkWord(input string name, input logic [7:0] addr, input logic [31:0] data);
        chk({name, "_we"}, 32'(mem_we), 32'd1);
        chk({name, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({name, "_wdata"}, mem_wdata, data);
        $display("write %s addr=%h data=%h", name, mem_addr, mem_wdata);
    endtask

    initial begin
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_data4  = 8'h00;
        rx_valid4 = 1'b0;
        reset_n   = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(rx_ready), 32'd1);

        // ---------------- table: basic 2-word load ----------------
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'hA0, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{8'hE3, 1'b1, 1'b1, 8'h00, 32'hE3A00001, 1'b0, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 1'b0, 8'h00, 32'hE3A00001, 1'b0, 1'b0});
        vecs.push_back('{8'h10, 1'b1, 1'b0, 8'h00, 32'hE3A00001, 1'b0, 1'b0});
        vecs.push_back('{8'hA0, 1'b1, 1'b0, 8'h00, 32'hE3A00001, 1'b0, 1'b0});
        vecs.push_back('{8'hE3, 1'b1, 1'b1, 8'h01, 32'hE3A01002, 1'b0, 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{8'h13, 1'b1, 1'b0, 8'h01, 32'hE3A01002, 1'b1, 1'b0});
`else
        vecs.push_back('{8'h00, 1'b0, 1'b0, 8'h01, 32'hE3A01002, 1'b1, 1'b0});
`endif
        vecs.push_back('{8'h00, 1'b0, 1'b0, 8'h01, 32'hE3A01002, 1'b1, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            rx_data  = vecs[i].data;
            rx_valid = vecs[i].valid;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            $display("vec %0d data=%h valid=%b we=%b addr=%h wdata=%h done=%b error=%b",
                     i, vecs[i].data, vecs[i].valid, mem_we, mem_addr, mem_wdata, done, error);
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
            chk($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(!vecs[i].dn));
            chk($sformatf("vec%0d_ready", i), 32'(rx_ready), 32'(!vecs[i].err));
        end
        chk("basic_we_count", 32'(weCount), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---------------- bad checksum ----------------
        doReset();
        weBase = weCount;
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h01); sendByte(8'h00); sendByte(8'hA0); sendByte(8'hE3);
        sendByte(8'h02); sendByte(8'h10); sendByte(8'hA0); sendByte(8'hE3);
        sendByte(8'h14);
        $display("bad csum: error=%b ready=%b cpu_reset=%b", error, rx_ready, cpu_reset);
        chk("badcs_error", 32'(error), 32'd1);
        chk("badcs_ready", 32'(rx_ready), 32'd0);
        chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        sendByte(8'hA5);
        idle(1);
        chk("badcs_sticky", 32'(error), 32'd1);
        chk("badcs_we_count", 32'(weCount - weBase), 32'd2);
`endif

        // ---------------- oversize on 16-word instance ----------------
        doReset();
        sendByte4(8'hA5); sendByte4(8'h10); sendByte4(8'h00);
        $display("dut4 N=16: error=%b ready=%b", error4, rx_ready4);
        chk("cap16_error", 32'(error4), 32'd0);
        chk("cap16_ready", 32'(rx_ready4), 32'd1);
        doReset();
        sendByte4(8'hA5); sendByte4(8'h11); sendByte4(8'h00);
        $display("dut4 N=17: error=%b ready=%b", error4, rx_ready4);
        chk("over_error", 32'(error4), 32'd1);
        chk("over_ready", 32'(rx_ready4), 32'd0);
        chk("over_cpu_reset", 32'(cpu_reset4), 32'd1);
        chk("over_done", 32'(done4), 32'd0);
        idle(1);
        chk("over_we_count", 32'(weCount4), 32'd0);
        chk("over_addr", 32'(mem_addr4), 32'd0);
        chk("over_wdata", mem_wdata4, 32'd0);

        // ---------------- noise and gapped valid ----------------
        doReset();
        weBase = weCount;
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h5A);
        idle(1);
        chk("noise_done", 32'(done), 32'd0);
        chk("noise_we_count", 32'(weCount - weBase), 32'd0);
        sendByte(8'hA5); idle(1);
        sendByte(8'h01); idle(1);
        sendByte(8'h00); idle(1);
        sendByte(8'h78); idle(1);
        sendByte(8'h56); idle(1);
        sendByte(8'h34); idle(1);
        sendByte(8'h12);
        chkWord("gap", 8'h00, 32'h12345678);
        idle(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h08);
`endif
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_cpu_reset", 32'(cpu_reset), 32'd0);
        idle(1);
        chk("gap_we_count", 32'(weCount - weBase), 32'd1);

        // ---------------- reload from DONE ----------------
        sendByte(8'h33);
        chk("done_ignores_byte", 32'(done), 32'd1);
        sendByte(8'hA5);
        $display("reload magic: cpu_reset=%b done=%b", cpu_reset, done);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hEF); sendByte(8'hBE); sendByte(8'hAD); sendByte(8'hDE);
        chkWord("reload", 8'h00, 32'hDEADBEEF);
        chk("reload_mid_cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h22);
`else
        idle(1);
`endif
        chk("reload_done_final", 32'(done), 32'd1);

        // ---------------- async reset mid-frame ----------------
        doReset();
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        chkWord("pre_rst", 8'h00, 32'h44332211);
        sendByte(8'h55);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset: ready=%b addr=%h wdata=%h cpu_reset=%b", rx_ready, mem_addr, mem_wdata, cpu_reset);
        chk("arst_ready", 32'(rx_ready), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready_back", 32'(rx_ready), 32'd1);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
        chkWord("restart", 8'h00, 32'h04030201);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h04);
`else
        idle(1);
`endif
        chk("restart_done", 32'(done), 32'd1);

        // ---------------- zero length ----------------
        doReset();
        weBase = weCount;
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero_not_done_yet", 32'(done), 32'd0);
        sendByte(8'h00);
`endif
        $display("zero length: done=%b cpu_reset=%b", done, cpu_reset);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        idle(1);
        chk("zero_we_count", 32'(weCount - weBase), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
